// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory controller slice.
//   state_t      - controller FSM encoding (also exported for debug)
//   SZ_B/H/W     - lsb access size codes
//   IO_MASK_HI_DEF - default addr[17:16] pattern selecting memory-mapped IO
//   byte_count() - number of byte cycles for a request
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] IO_MASK_HI_DEF = 2'b11;

  // Fetches are always a full word; lsb size codes map to 1/2/4 bytes.
  function automatic logic [2:0] byte_count(input logic is_fetch, input logic [1:0] size);
    logic [2:0] n;
    if (is_fetch) begin
      n = 3'd4;
    end else begin
      case (size)
        SZ_B:    n = 3'd1;
        SZ_H:    n = 3'd2;
        default: n = 3'd4;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the fetch, lsb and RAM/IO signals of mem_ctrl.
//   slave  modport: the controller's view
//   master modport: the requesters' and RAM's view
//
// Handshake: a requester raises its valid (if_valid / mem_ctrl_out_config)
// with address/data stable and holds everything until the matching
// one-cycle done pulse (if_done / mem_ctrl_in_config); the returned data is
// valid in that same cycle. There is no backpressure beyond holding.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              mem_ctrl_out_config;
  logic              mem_ctrl_out_ls;
  logic [ADDR_W-1:0] mem_ctrl_out_addr;
  logic [31:0]       mem_ctrl_out_data;
  logic [1:0]        lsb_size;
  logic              mem_ctrl_in_config;
  logic [31:0]       mem_ctrl_in_data;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  if_valid, if_addr,
    output if_done, if_data,
    input  mem_ctrl_out_config, mem_ctrl_out_ls, mem_ctrl_out_addr,
    input  mem_ctrl_out_data, lsb_size,
    output mem_ctrl_in_config, mem_ctrl_in_data,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_valid, if_addr,
    input  if_done, if_data,
    output mem_ctrl_out_config, mem_ctrl_out_ls, mem_ctrl_out_addr,
    output mem_ctrl_out_data, lsb_size,
    input  mem_ctrl_in_config, mem_ctrl_in_data,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: two-way grant between fetch and lsb.
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - arbitration cycle (controller free and globally enabled)
//   req_if/ls   - qualified requests
//   gnt_if/ls   - combinational one-hot grant
// On contention the requester that did not win the previous contention
// wins; last_grant only moves when both were requesting.
module mem_ctrl_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_if,
  input  logic req_ls,
  output logic gnt_if,
  output logic gnt_ls
);
  import mem_pkg::*;

  logic last_ls_q, last_ls_d;  // 0 = fetch won last contention

  always_comb begin
    gnt_ls    = en && req_ls && (!req_if || !last_ls_q);
    gnt_if    = en && req_if && (!req_ls || last_ls_q);
    last_ls_d = last_ls_q;
    if (en && req_if && req_ls) last_ls_d = gnt_ls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_ls_q <= 1'b0;
    else        last_ls_q <= last_ls_d;
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares the byte-wide RAM/IO port between ifetch and the lsb.
//   clk, rst        - clock, asynchronous active-low reset
//   rdy             - global enable; low freezes every flop
//   rollback_config - flush pulse; aborts an in-flight fetch
//   bus             - fetch / lsb / RAM signals (mem_ctrl_if.slave)
//   dbg_state       - current FSM state
// Each request is split into byte cycles; reads are assembled little-endian
// and arrive one cycle after their address, so a read runs N+1 cycles.
module mem_ctrl #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_MASK_HI = mem_pkg::IO_MASK_HI_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback_config,
  mem_ctrl_if.slave        bus,
  output mem_pkg::state_t  dbg_state
);
  import mem_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       data_q, data_d;     // store bytes (current at [7:0]) or load assembly
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic              src_ls_q, src_ls_d; // 1 = lsb owns the port
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              ls_done_q, ls_done_d;
  logic [31:0]       ls_data_q, ls_data_d;

  logic              arb_en, req_if, req_ls, gnt_if, gnt_ls;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        rd_idx;
  logic [31:0]       rd_word;
  logic              io_stall, req_io_stall;

  // A requester is masked during its own done cycle (it still holds valid),
  // and rollback keeps a fetch from being granted.
  assign arb_en = rdy && (state_q == ST_IDLE || state_q == ST_DONE);
  assign req_if = bus.if_valid && !rollback_config && !if_done_q;
  assign req_ls = bus.mem_ctrl_out_config && !ls_done_q;

  mem_ctrl_arb u_arb (
    .clk    (clk),
    .rst_n  (rst),
    .en     (arb_en),
    .req_if (req_if),
    .req_ls (req_ls),
    .gnt_if (gnt_if),
    .gnt_ls (gnt_ls)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_a_d    = mem_a_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    src_ls_d   = src_ls_q;
    mem_wr_d   = mem_wr_q;
    mem_dout_d = mem_dout_q;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_done_d  = 1'b0;
    ls_data_d  = ls_data_q;

    // In READ, cnt counts cycles; mem_din carries byte cnt-1.
    rd_idx  = cnt_q[1:0] - 2'd1;
    rd_word = data_q;
    rd_word[{rd_idx, 3'b000} +: 8] = bus.mem_din;

    req_addr     = gnt_if ? bus.if_addr : bus.mem_ctrl_out_addr;
    req_io_stall = (req_addr[17:16] == IO_MASK_HI) && bus.io_buffer_full;
    io_stall     = (addr_q[17:16] == IO_MASK_HI) && bus.io_buffer_full;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d  = ST_IDLE;
        mem_wr_d = 1'b0;
        if (gnt_if || gnt_ls) begin
          addr_d   = req_addr;
          mem_a_d  = req_addr;
          src_ls_d = gnt_ls;
          nbytes_d = byte_count(gnt_if, bus.lsb_size);
          cnt_d    = 3'd0;
          if (gnt_ls && !bus.mem_ctrl_out_ls) begin
            state_d    = ST_WRITE;
            data_d     = bus.mem_ctrl_out_data;
            mem_dout_d = bus.mem_ctrl_out_data[7:0];
            mem_wr_d   = !req_io_stall;
          end else begin
            state_d = ST_READ;
            data_d  = 32'd0;
          end
        end
      end

      ST_READ: begin
        if (!src_ls_q && rollback_config) begin
          state_d  = ST_IDLE;
          mem_wr_d = 1'b0;
        end else begin
          if (cnt_q != 3'd0) data_d = rd_word;
          if (cnt_q == nbytes_q) begin
            state_d = ST_DONE;
            if (src_ls_q) begin
              ls_done_d = 1'b1;
              ls_data_d = rd_word;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rd_word;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < nbytes_q) mem_a_d = mem_a_q + ADDR_W'(1);
          end
        end
      end

      ST_WRITE: begin
        // mem_wr_q high means the byte on the pins is written this cycle;
        // low means it is being held for a full IO buffer.
        if (mem_wr_q) begin
          if (cnt_q + 3'd1 == nbytes_q) begin
            state_d   = ST_DONE;
            mem_wr_d  = 1'b0;
            ls_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            data_d     = data_q >> 8;
            mem_dout_d = data_q[15:8];
            mem_a_d    = mem_a_q + ADDR_W'(1);
            mem_wr_d   = !io_stall;
          end
        end else begin
          mem_wr_d = !io_stall;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      mem_a_q    <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      src_ls_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_done_q  <= 1'b0;
      ls_data_q  <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_a_q    <= mem_a_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      src_ls_q   <= src_ls_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      ls_done_q  <= ls_done_d;
      ls_data_q  <= ls_data_d;
    end
  end

  assign bus.if_done            = if_done_q;
  assign bus.if_data            = if_data_q;
  assign bus.mem_ctrl_in_config = ls_done_q;
  assign bus.mem_ctrl_in_data   = ls_data_q;
  assign bus.mem_a              = mem_a_q;
  assign bus.mem_wr             = mem_wr_q;
  assign bus.mem_dout           = mem_dout_q;
  assign dbg_state              = state_q;
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Owns the single byte-wide RAM/IO port and shares it between the instruction fetch unit and the load/store buffer (lsb). Each requester issues one word, half or byte request and holds it until a one-cycle done pulse. The controller serialises each request into per-byte RAM cycles, assembles read bytes little-endian, and aborts fetches on rollback. Sits between ifetch/lsb and the top-level RAM/IO pins.

Parameters:
ADDR_W, 32, address width of requests and mem_a
IO_MASK_HI, 2'b11, value of addr[17:16] that selects memory-mapped IO

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
rdy  in  1  global enable; when low all state and outputs hold
rollback_config  in  1  pipeline flush pulse
if_valid  in  1  fetch request, held until if_done
if_addr  in  32  fetch address (4-byte read)
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
mem_ctrl_out_config  in  1  lsb request valid, held until mem_ctrl_in_config
mem_ctrl_out_ls  in  1  1 = load, 0 = store
mem_ctrl_out_addr  in  32  lsb address
mem_ctrl_out_data  in  32  store data (low bytes used)
lsb_size  in  2  00 byte, 01 half, 10 word
mem_ctrl_in_config  out  1  one-cycle done pulse to lsb
mem_ctrl_in_data  out  32  load data, zero-extended (lsb sign-extends)
mem_din  in  8  RAM/IO read byte
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1 = write this cycle
io_buffer_full  in  1  IO write FIFO full

Behaviour:
- Reset (rst low, asynchronous): state IDLE; if_done, mem_ctrl_in_config, mem_wr = 0; mem_a, mem_dout, if_data, mem_ctrl_in_data = 0; last_grant = fetch.
- RAM contract: mem_din in cycle c holds the byte addressed by mem_a in cycle c-1. A write occurs in any cycle with mem_wr=1.
- States: IDLE, READ, WRITE, DONE. All outputs are registered.
- IDLE arbitration: if only one requester is valid, grant it. If both are valid, grant the one not in last_grant, then update last_grant. A request is not sampled in the cycle its own done pulse is high.
- Byte count N: fetch 4. lsb = 1, 2 or 4 per lsb_size.
- READ: mem_a steps addr, addr+1, ..., addr+N-1 in consecutive cycles with mem_wr=0. Bytes land at buffer[8k+7:8k]; unused upper bytes are 0. The done pulse fires exactly N+2 cycles after the grant cycle.
- WRITE: mem_wr=1 with mem_dout = data byte k at addr+k for N consecutive cycles. The done pulse fires N+1 cycles after the grant.
- IO stall: if addr[17:16]==IO_MASK_HI and io_buffer_full=1, hold the current byte with mem_wr=0 until full drops. The stall extends latency and loses no bytes.
- DONE: pulse if_done or mem_ctrl_in_config for exactly one cycle, drive the data, then return to IDLE.
- Rollback, fetch in flight: abort. Next state is IDLE, mem_wr=0, and no if_done is produced. A rollback coinciding with the if_done cycle still lets that pulse out, and ifetch discards it.
- Rollback, lsb request in flight: ignored; the lsb access completes normally.
- Rollback in IDLE: no fetch is granted that cycle.
- mem_a after done: holds its last value with mem_wr=0.
- Address arithmetic: addr+k wraps modulo 2^32.
- rdy low: complete freeze, including byte counter and arbitration; pulses stay high until rdy returns.

Decomposition:
- Shared package mem_pkg: state encoding; size codes SZ_B/SZ_H/SZ_W; IO_MASK_HI; byte-count function.
- One natural sub-module, mem_ctrl_arb: 2-way alternating-priority grant with last_grant register.
- Byte FSM and assembly stay in mem_ctrl.

Test Plan:
- Fetch only, if_addr=0x100, RAM bytes 13,05,00,00 -> mem_a 0x100..0x103, if_done exactly 6 cycles after grant, if_data=0x00000513.
- lsb store word 0xDEADBEEF at 0x200 -> mem_wr high 4 cycles with mem_dout EF,BE,AD,DE at 0x200..0x203, mem_ctrl_in_config 5 cycles after grant.
- Simultaneous if_valid and lsb load byte at 0x204 (byte 0x80), last_grant=fetch -> lsb served first, mem_ctrl_in_data=0x00000080; fetch served next with no idle gap beyond DONE.
- Rollback asserted 2 cycles into a fetch -> no if_done, mem_wr stays 0, IDLE next cycle, then a pending lsb request is granted.
- Byte store 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 during the stall, then one write of 0x41, done 3 cycles later than the unstalled case.
- Assert rst low mid-WRITE (asynchronously) -> mem_wr drops immediately, state IDLE, no done pulse after release.
